// File: rtl/cv_mem_responder_if.sv
// Word request/response bus between the CV data loader
// and its memory responder.
interface cv_mem_responder_if;
  logic        rvalid;
  logic [25:0] raddr;
  logic        rready;
  logic [31:0] rdata;
  logic        wvalid;
  logic [25:0] waddr;
  logic [31:0] wdata;
  logic        wready;

  modport master (
    output rvalid, raddr, wvalid, waddr, wdata,
    input  rready, rdata, wready
  );

  modport slave (
    input  rvalid, raddr, wvalid, waddr, wdata,
    output rready, rdata, wready
  );
endinterface

// File: rtl/cv_mem_responder.sv
// Single-outstanding word memory responder with
// programmable read/write latency and sticky range error.
module cv_mem_responder #(
  parameter int DEPTH     = 65536,
  parameter int AW        = 16,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  cv_mem_responder_if.slave    bus,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic          bad_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          acc_rd, acc_wr, ld_rd;
  logic [25:0]   acc_addr;
  logic          acc_bad;
  logic [AW-1:0] rd_idx;
  logic          rd_bad;

  function automatic logic oor(logic [25:0] a);
    return 32'(a) >= 32'(DEPTH);
  endfunction

  assign acc_addr = acc_wr ? bus.waddr : bus.raddr;
  assign acc_bad  = oor(acc_addr);

  // With single-cycle read latency the array is read
  // straight from the request address in IDLE.
  assign rd_idx = (state == IDLE) ? bus.raddr[AW-1:0]
                                  : idx_q;
  assign rd_bad = (state == IDLE) ? oor(bus.raddr)
                                  : bad_q;

  assign bus.rready = (state == RD_RESP);
  assign bus.wready = (state == WR_RESP);
  assign bus.rdata  = rdata_q;
  assign busy       = (state != IDLE);

  // Next state, latency count and accept strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    ld_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.wvalid) begin
          acc_wr = 1'b1;
          cnt_n  = CW'(WRITE_LAT - 1);
          state_n = (WRITE_LAT == 1) ? WR_RESP : WR_WAIT;
        end else if (bus.rvalid) begin
          acc_rd = 1'b1;
          cnt_n  = CW'(READ_LAT - 1);
          if (READ_LAT == 1) begin
            state_n = RD_RESP;
            ld_rd   = 1'b1;
          end else begin
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = RD_RESP;
          ld_rd   = 1'b1;
        end
      end
      WR_WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = WR_RESP;
      end
      RD_RESP: state_n = IDLE;
      WR_RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, request latch, read data and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (acc_rd || acc_wr) begin
        idx_q <= acc_addr[AW-1:0];
        bad_q <= acc_bad;
      end
      if (acc_wr) data_q <= bus.wdata;
      if (ld_rd) rdata_q <= rd_bad ? '0 : mem[rd_idx];
      if ((acc_rd || acc_wr) && acc_bad) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  // Commit a write at the edge ending its wready cycle.
  always_ff @(posedge clk) begin
    if (state == WR_RESP && !bad_q) mem[idx_q] <= data_q;
  end

endmodule
